inst_queue: RTL
===============

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADDR_WIDTH SHALL default to 32 and set the instruction address width.
REQ-003 Parameter INST_WIDTH SHALL default to 32 and set the instruction word width; values below 32 are illegal.
REQ-004 Parameter DEPTH SHALL default to 4 and set the entry count; only powers of two ≥2 are legal.
REQ-005 Ports SHALL be as follows (CW = log2(DEPTH)+1):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  discard all entries; driven by the branch_flag from decode.
- push_valid  input  1  IF presents an entry.
- push_ready  output  1  queue can accept.
- push_addr  input  ADDR_WIDTH  PC of the pushed instruction.
- push_inst  input  INST_WIDTH  pushed instruction.
- pop_valid  output  1  head entry is valid.
- pop_ready  input  1  decode consumes the head; decode drives the inverse of stall_request.
- pop_addr  output  ADDR_WIDTH  head PC.
- pop_inst  output  INST_WIDTH  head instruction.
- pop_is_ctrl  output  1  the head is JAL, BEQ, BNE or SPECIAL/JALR.
- count  output  CW  occupied entries.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Function
REQ-006 A push SHALL occur on a rising edge when push_valid && push_ready.
REQ-007 A pop SHALL occur on a rising edge when pop_valid && pop_ready.
REQ-008 push_ready SHALL equal !full, registered-state only, and SHALL have no combinational path from pop_ready.
REQ-009 pop_valid SHALL equal !empty; the queue has no bypass path, so a push into an empty queue appears at the head one cycle later.
REQ-010 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-011 count SHALL update each cycle as follows:
- +1 on push only.
- -1 on pop only.
- unchanged on simultaneous push and pop.
REQ-012 Simultaneous push and pop SHALL be legal at any non-full, non-empty occupancy.
- When full, only the pop proceeds and the freed slot is usable the following cycle.
- When empty, only the push proceeds.
REQ-013 pop_addr and pop_inst SHALL show the head entry when pop_valid=1, and SHALL be 0 when empty.
REQ-014 pop_is_ctrl SHALL be combinational from pop_inst[31:26] and pop_inst[5:0]. It SHALL be 1 for:
- opcode 000011 (JAL).
- opcode 000100 (BEQ).
- opcode 000101 (BNE).
- opcode 000000 with funct 001001 (JALR).
It SHALL be 0 otherwise, including when empty.
REQ-015 Flush SHALL take priority over push and pop in the same cycle.
- The next edge sets wr_ptr, rd_ptr and count to 0.
- A push offered in the flush cycle is discarded.
- A pop in the flush cycle is considered consumed by decode.
- Storage contents need not be cleared.
REQ-016 push_ready SHALL remain !full during a flush cycle; it is not forced low.
REQ-017 Storage entries that are not valid SHALL never influence any output.
REQ-018 count SHALL never exceed DEPTH and never underflow; a pop with pop_valid=0 SHALL have no effect.

Reset
REQ-019 Asserting rst low SHALL immediately clear wr_ptr, rd_ptr and count.
REQ-020 While rst is low, outputs SHALL be:
- push_ready=1, pop_valid=0, empty=1, full=0.
- pop_addr=0, pop_inst=0, pop_is_ctrl=0.
REQ-021 Reset asserted mid-operation SHALL discard all entries.
- No push or pop SHALL complete on the edge coinciding with release.
- Operation SHALL resume on the first edge after rst goes high.

Verification
REQ-022 Fill/drain (DEPTH=4, pop_ready=0): push PCs 0x100, 0x104, 0x108, 0x10C.
- Expect count=4, full=1, push_ready=0.
- Then set pop_ready=1: pops return 0x100..0x10C in order, empty=1 after the 4th pop.
REQ-023 Full with simultaneous push/pop: at count=4, assert push_valid and pop_ready together.
- Expect only the pop to occur: count=3.
- The pushed entry is accepted the next cycle: count=4 again.
REQ-024 Wrap-around: stream 10 entries with pop_ready=1 held continuously.
- Expect every PC in order with no loss.
- Expect count to stay at 1 in steady state after the first-cycle latency.
REQ-025 Predecode: push, in order:
- 0x0C000010 (JAL)
- 0x10220003 (BEQ)
- 0x03E00009 (JALR)
- 0x24420001 (ADDIU)
Expect pop_is_ctrl at the head to read 1, 1, 1, 0 respectively.
REQ-026 Flush: with count=3, assert flush together with push_valid and pop_ready.
- Next cycle: count=0, empty=1, pop_addr=0.
- The flushed-cycle push is absent from the queue.
REQ-027 Async reset: with count=2, drive rst low between edges.
- Expect empty=1 and pop_valid=0 immediately, without waiting for a clock edge.
- After release, a single push makes pop_valid=1 one cycle later.

Source files
------------

// File: rtl/inst_queue_if.sv
// Handshake bundle between instruction fetch, the instruction queue and decode.
// The queue takes the slave side; the fetch/decode pair (or a bench) takes master.
interface inst_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  push_valid;
  logic                  push_ready;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [INST_WIDTH-1:0] push_inst;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [ADDR_WIDTH-1:0] pop_addr;
  logic [INST_WIDTH-1:0] pop_inst;
  logic                  pop_is_ctrl;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;

  modport master (
    output flush, push_valid, push_addr, push_inst, pop_ready,
    input  push_ready, pop_valid, pop_addr, pop_inst, pop_is_ctrl, count, full, empty
  );

  modport slave (
    input  flush, push_valid, push_addr, push_inst, pop_ready,
    output push_ready, pop_valid, pop_addr, pop_inst, pop_is_ctrl, count, full, empty
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode, with flush and a head predecoder
// that flags control-transfer instructions (JAL, BEQ, BNE, JALR).
module inst_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input logic         clk,
  input logic         rst,
  inst_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_d [DEPTH];

  logic       full, empty, push_fire, pop_fire;
  logic [5:0] opcode, funct;

  // Status depends on registered occupancy only, so push_ready never sees pop_ready.
  assign full      = (count_q == CountFull);
  assign empty     = (count_q == '0);
  assign push_fire = q.push_valid && !full;
  assign pop_fire  = q.pop_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        addr_d[wr_ptr_q] = q.push_addr;
        inst_d[wr_ptr_q] = q.push_inst;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: stale slots are masked by the occupancy count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    inst_q <= inst_d;
  end

  always_comb begin
    q.push_ready = !full;
    q.pop_valid  = !empty;
    q.full       = full;
    q.empty      = empty;
    q.count      = count_q;
    q.pop_addr   = empty ? '0 : addr_q[rd_ptr_q];
    q.pop_inst   = empty ? '0 : inst_q[rd_ptr_q];
    opcode       = q.pop_inst[31:26];
    funct        = q.pop_inst[5:0];
    q.pop_is_ctrl = (opcode == 6'b000011) || (opcode == 6'b000100) ||
                    (opcode == 6'b000101) ||
                    ((opcode == 6'b000000) && (funct == 6'b001001));
  end
endmodule
